ws2812_frame_ctrl: RTL
======================

Name: ws2812_frame_ctrl

Overview:
Frame-level controller for the LED chain. On a start pulse it reads N_LEDS 24-bit pixel words from the external pixel RAM. It serialises each word MSB-first onto the single-wire WS2812 line with per-bit high/low timing, then holds the line low for the latch period. It sits between the snake/game logic, which fills the pixel RAM, and the LED data pin, and owns all bit sequencing and timing.

Parameters:
W, 24, bits per pixel word (GRB as stored, MSB sent first)
N_LEDS, 64, pixels per frame (>=1)
ADDR_W, 6, pixel RAM address width (2**ADDR_W >= N_LEDS)
T_BIT, 63, clk cycles per bit period (1.25 us at 50 MHz)
T0H, 20, high cycles for a 0 bit (< T1H)
T1H, 40, high cycles for a 1 bit (< T_BIT)
RESET_CYC, 2500, low cycles for latch (>= 50 us)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to send a frame; sampled only in IDLE
pix_rd  out  1  pixel RAM read strobe
pix_addr  out  ADDR_W  pixel RAM read address
pix_data  in  W  read data, valid exactly 1 cycle after pix_rd
led_dout  out  1  WS2812 serial data, registered
busy  out  1  high from FETCH through end of LATCH
done  out  1  one-cycle pulse in final LATCH cycle

Behaviour:
- Reset (async, rst_n=0): led_dout=0, busy=0, done=0, pix_rd=0, pix_addr=0. State is IDLE and all counters are cleared. Takes effect immediately, including mid-bit and mid-frame. No partial frame resumes.
- States: IDLE -> FETCH -> LOAD -> SEND -> LATCH -> IDLE.
- IDLE: if start=1, go to FETCH. Otherwise stay.
- FETCH (1 cycle): pix_rd=1, pix_addr=0, busy=1.
- LOAD (1 cycle): capture pix_data into shift_buf. Clear bit_cnt, pix_cnt and tick.
- SEND: tick counts 0..T_BIT-1. led_dout=1 while tick < (shift_buf[W-1] ? T1H : T0H), else 0. led_dout is registered, so the first SEND cycle drives the high level.
- End of each bit period (tick=T_BIT-1):
  - shift_buf shifts left by 1 and bit_cnt increments.
  - At bit_cnt=W-1: load shift_buf from next_buf and increment pix_cnt. If pix_cnt=N_LEDS-1, go to LATCH instead.
- Prefetch: in the first cycle of bit 0 of pixel k with k < N_LEDS-1, pix_rd=1 and pix_addr=k+1. next_buf captures pix_data on the following cycle.
  - Consequence: there is no gap between pixels, and the line is continuous across the whole frame.
  - No read is issued for the last pixel. Each address 0..N_LEDS-1 is read exactly once.
- LATCH: led_dout=0 for RESET_CYC cycles. done=1 in the last LATCH cycle, with busy still 1. Next state is IDLE, where busy=0.
- Frame length in cycles, from the start-sampling edge to the first IDLE cycle: 2 + N_LEDS*W*T_BIT + RESET_CYC.
- start while not in IDLE, including the done cycle: ignored, no queuing.
- pix_rd is never asserted outside FETCH and the prefetch cycles.
- Counter widths: tick sized for T_BIT-1, bit_cnt 5 bits, pix_cnt ADDR_W+1 bits, latch counter sized for RESET_CYC-1. No wrap occurs within legal parameters.

Decomposition:
- Package ws2812_pkg:
  - W and default timing constants.
  - State enum {IDLE, FETCH, LOAD, SEND, LATCH}.
  - Localparam for counter widths derived via $clog2.
- Sub-module ws2812_bit_encoder:
  - Inputs: clk, rst_n, en, bit_val.
  - Outputs: tick counter, dout, bit_end pulse.
  - Owns T0H/T1H/T_BIT timing.
- The top-level FSM owns addressing, buffering and latch.

Test Plan:
Use sim parameters N_LEDS=3, T_BIT=6, T0H=2, T1H=4, RESET_CYC=10, and RAM {0:0xFF0000, 1:0x000000, 2:0xA5A5A5}.
1. Reset: hold rst_n=0 with random start -> led_dout=0, busy=0, done=0, pix_rd=0. Assert rst_n asynchronously mid-cycle -> outputs clear without waiting for a clk edge.
2. Full frame: start pulse -> busy for exactly 2+3*24*6+10=444 cycles. Required high-time pattern:
   - Pixel 0: 8 high pulses of 4 cycles, then 16 of 2 cycles.
   - Pixel 1: 24 pulses of 2 cycles.
   - Pixel 2: pattern 4,2,4,2,2,4,2,4 repeated 3 times.
   - Then 10 low cycles, with done=1 in cycle 444 only.
3. Read sequencing: same frame -> pix_rd pulses at addr 0 (FETCH), addr 1 (first cycle of pixel 0 bit 0) and addr 2 (first cycle of pixel 1 bit 0). Exactly 3 reads, with no read during pixel 2.
4. Start collisions: start pulsed mid-SEND and again in the done cycle -> both ignored and busy falls after one frame. Start in the first IDLE cycle after done -> new frame with FETCH on the next cycle.
5. Reset mid-frame: rst_n=0 during pixel 1 bit 10 -> led_dout=0 and busy=0 immediately. After release, start -> FETCH reads addr 0 and the frame replays from pixel 0.
6. Boundary N_LEDS=1 with RAM {0:0x800001} -> one FETCH read only, no prefetch. Bit 0 has 4-cycle high, bits 1..22 have 2-cycle high, bit 23 has 4-cycle high. busy length = 2+144+10=156.

Source files
------------

// File: rtl/ws2812_pkg.sv
// Shared constants, state encoding and counter-width helper for the WS2812 frame path.
// Pure declarations: no latency, no flow control.
package ws2812_pkg;

    localparam int PIX_W         = 24;
    localparam int N_LEDS_DEF    = 64;
    localparam int ADDR_W_DEF    = 6;
    localparam int T_BIT_DEF     = 63;
    localparam int T0H_DEF       = 20;
    localparam int T1H_DEF       = 40;
    localparam int RESET_CYC_DEF = 2500;

    localparam int BIT_CNT_W = 5;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SEND,
        LATCH
    } state_t;

    // Width of a counter that must reach n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int TICK_W_DEF  = cnt_w(T_BIT_DEF);
    localparam int LATCH_W_DEF = cnt_w(RESET_CYC_DEF);

endpackage

// File: rtl/ws2812_frame_ctrl_if.sv
// Pixel RAM read port: strobe + address out, data back one cycle after the strobe.
// Fixed read latency of 1 cycle; no backpressure, the RAM must always answer.
interface ws2812_frame_ctrl_if
    import ws2812_pkg::*;
#(
    parameter int W      = PIX_W,
    parameter int ADDR_W = ADDR_W_DEF
) ();

    logic              pix_rd;
    logic [ADDR_W-1:0] pix_addr;
    logic [W-1:0]      pix_data;

    modport master (
        output pix_rd,
        output pix_addr,
        input  pix_data
    );

    modport slave (
        input  pix_rd,
        input  pix_addr,
        output pix_data
    );

endinterface

// File: rtl/ws2812_bit_encoder.sv
// Turns one bit value per T_BIT period into the WS2812 high/low waveform on a registered dout.
// en means "the next cycle is a send cycle"; dout is one cycle behind en, no backpressure.
module ws2812_bit_encoder
    import ws2812_pkg::*;
#(
    parameter int T_BIT = T_BIT_DEF,
    parameter int T0H   = T0H_DEF,
    parameter int T1H   = T1H_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      bit_val,
    output logic [cnt_w(T_BIT)-1:0]   tick,
    output logic                      dout,
    output logic                      bit_end
);

    localparam int TICK_W = cnt_w(T_BIT);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(T_BIT - 1);
    localparam logic [TICK_W-1:0] HI0       = TICK_W'(T0H);
    localparam logic [TICK_W-1:0] HI1       = TICK_W'(T1H);

    logic              running;
    logic [TICK_W-1:0] tick_inc;

    assign tick_inc = tick + 1'b1;
    assign bit_end  = running && (tick == TICK_LAST);

    // Every bit period opens high (T0H >= 1), so a new bit never needs its value early.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running <= 1'b0;
            tick    <= '0;
            dout    <= 1'b0;
        end else begin
            running <= en;
            if (!en) begin
                tick <= '0;
                dout <= 1'b0;
            end else if (!running || bit_end) begin
                tick <= '0;
                dout <= 1'b1;
            end else begin
                tick <= tick_inc;
                dout <= (tick_inc < (bit_val ? HI1 : HI0));
            end
        end
    end

endmodule

// File: rtl/ws2812_frame_ctrl.sv
// Frame controller: fetches N_LEDS pixels, streams them MSB-first to the LED line, then latches.
// Start to idle takes 2 + N_LEDS*W*T_BIT + RESET_CYC cycles; start is dropped while busy.
module ws2812_frame_ctrl
    import ws2812_pkg::*;
#(
    parameter int W         = PIX_W,
    parameter int N_LEDS    = N_LEDS_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int T_BIT     = T_BIT_DEF,
    parameter int T0H       = T0H_DEF,
    parameter int T1H       = T1H_DEF,
    parameter int RESET_CYC = RESET_CYC_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    ws2812_frame_ctrl_if.master         pix,
    output logic                        led_dout,
    output logic                        busy,
    output logic                        done
);

    localparam int TICK_W  = cnt_w(T_BIT);
    localparam int LATCH_W = cnt_w(RESET_CYC);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST   = BIT_CNT_W'(W - 1);
    localparam logic [ADDR_W:0]      PIX_LAST   = (ADDR_W + 1)'(N_LEDS - 1);
    localparam logic [LATCH_W-1:0]   LATCH_LAST = LATCH_W'(RESET_CYC - 1);

    state_t               state;
    state_t               state_nxt;
    logic [W-1:0]         shift_buf;
    logic [W-1:0]         next_buf;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [ADDR_W:0]      pix_cnt;
    logic [ADDR_W:0]      pix_inc;
    logic [LATCH_W-1:0]   latch_cnt;
    logic [TICK_W-1:0]    tick;
    logic                 pref_rd;
    logic                 pref_q;
    logic                 bit_end;
    logic                 last_bit;
    logic                 enc_en;

    assign pix_inc  = pix_cnt + 1'b1;
    assign last_bit = (bit_cnt == BIT_LAST) && (pix_cnt == PIX_LAST);

    // Next pixel is requested on the first cycle of the current pixel, long before it is needed.
    assign pref_rd  = (state == SEND) && (bit_cnt == '0) && (tick == '0) && (pix_cnt != PIX_LAST);
    assign enc_en   = (state == LOAD) || ((state == SEND) && !(bit_end && last_bit));

    assign pix.pix_rd   = (state == FETCH) || pref_rd;
    assign pix.pix_addr = pref_rd ? pix_inc[ADDR_W-1:0] : '0;
    assign busy         = (state != IDLE);
    assign done         = (state == LATCH) && (latch_cnt == LATCH_LAST);

    ws2812_bit_encoder #(
        .T_BIT (T_BIT),
        .T0H   (T0H),
        .T1H   (T1H)
    ) u_enc (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (enc_en),
        .bit_val (shift_buf[W-1]),
        .tick    (tick),
        .dout    (led_dout),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FETCH;
            FETCH:   state_nxt = LOAD;
            LOAD:    state_nxt = SEND;
            SEND:    if (bit_end && last_bit) state_nxt = LATCH;
            LATCH:   if (latch_cnt == LATCH_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_buf <= '0;
            next_buf  <= '0;
            bit_cnt   <= '0;
            pix_cnt   <= '0;
            latch_cnt <= '0;
            pref_q    <= 1'b0;
        end else begin
            pref_q <= pref_rd;
            if (pref_q) begin
                next_buf <= pix.pix_data;
            end
            case (state)
                LOAD: begin
                    shift_buf <= pix.pix_data;
                    bit_cnt   <= '0;
                    pix_cnt   <= '0;
                    latch_cnt <= '0;
                end
                SEND: begin
                    if (bit_end) begin
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            if (pix_cnt != PIX_LAST) begin
                                shift_buf <= next_buf;
                                pix_cnt   <= pix_inc;
                            end
                        end else begin
                            shift_buf <= {shift_buf[W-2:0], 1'b0};
                            bit_cnt   <= bit_cnt + 1'b1;
                        end
                    end
                end
                LATCH: begin
                    if (!done) begin
                        latch_cnt <= latch_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
